// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, issues one outstanding instruction-memory request at a time
// and presents the returned word to decode; execute redirects squash stale fetches.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_VECTOR    = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTRUCTION = 32'h0000_0013
) (
    input  logic        pll_1_200MHz,
    input  logic        pll_1_locked_synced,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        fetch_valid,
    input  logic        decode_ready,
    output logic [31:0] fetch_instruction,
    output logic [31:0] fetch_pc,
    output logic [31:0] fetch_pc_plus_4,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        fetch_misaligned,
    output logic [31:0] fetch_count
);

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t          state;
    logic [XLEN-1:0] pc;
    logic            discard;

    // Request is suppressed during reset and on the cycle a redirect changes the PC
    assign imem_req_valid = pll_1_locked_synced && (state == S_REQ) && !redirect_valid;
    assign imem_req_addr  = pc;

    always_ff @(posedge pll_1_200MHz or negedge pll_1_locked_synced) begin
        if (!pll_1_locked_synced) begin
            state             <= S_REQ;
            pc                <= RESET_VECTOR;
            discard           <= 1'b0;
            fetch_valid       <= 1'b0;
            fetch_instruction <= NOP_INSTRUCTION;
            fetch_pc          <= RESET_VECTOR;
            fetch_pc_plus_4   <= RESET_VECTOR + PC_STEP;
            fetch_misaligned  <= 1'b0;
            fetch_count       <= '0;
        end else begin
            fetch_misaligned <= 1'b0;
            if (redirect_valid) begin
                // Redirect wins over every other event in every state
                pc               <= {redirect_target[XLEN-1:2], 2'b00};
                fetch_misaligned <= |redirect_target[1:0];
                case (state)
                    S_REQ: state <= S_REQ;
                    S_WAIT: begin
                        if (imem_rsp_valid) begin
                            discard <= 1'b0;
                            state   <= S_REQ;
                        end else begin
                            discard <= 1'b1;
                        end
                    end
                    S_HOLD: begin
                        fetch_valid       <= 1'b0;
                        fetch_instruction <= NOP_INSTRUCTION;
                        if (decode_ready) begin
                            fetch_count <= fetch_count + XLEN'(1);
                        end
                        state <= S_REQ;
                    end
                    default: state <= S_REQ;
                endcase
            end else begin
                case (state)
                    S_REQ: begin
                        if (imem_req_ready) begin
                            state <= S_WAIT;
                        end
                    end
                    S_WAIT: begin
                        if (imem_rsp_valid) begin
                            if (discard) begin
                                discard <= 1'b0;
                                state   <= S_REQ;
                            end else begin
                                fetch_instruction <= imem_rsp_data;
                                fetch_pc          <= pc;
                                fetch_pc_plus_4   <= pc + PC_STEP;
                                pc                <= pc + PC_STEP;
                                fetch_valid       <= 1'b1;
                                state             <= S_HOLD;
                            end
                        end
                    end
                    S_HOLD: begin
                        if (decode_ready) begin
                            fetch_valid       <= 1'b0;
                            fetch_instruction <= NOP_INSTRUCTION;
                            fetch_count       <= fetch_count + XLEN'(1);
                            state             <= S_REQ;
                        end
                    end
                    default: state <= S_REQ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit; the bench plays instruction memory,
// decode and execute cycle by cycle from a single sequence of scenario tasks.
`timescale 1ns/100ps
module tb_instruction_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        fetch_valid;
    logic        decode_ready = 1'b0;
    logic [31:0] fetch_instruction;
    logic [31:0] fetch_pc;
    logic [31:0] fetch_pc_plus_4;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_target = '0;
    logic        fetch_misaligned;
    logic [31:0] fetch_count;

    int n_checks = 0;
    int n_fail   = 0;

    instruction_fetch_unit #(
        .RESET_VECTOR   (32'h0000_0000),
        .NOP_INSTRUCTION(NOP)
    ) dut (
        .pll_1_200MHz       (clk),
        .pll_1_locked_synced(rst_n),
        .imem_req_valid     (imem_req_valid),
        .imem_req_ready     (imem_req_ready),
        .imem_req_addr      (imem_req_addr),
        .imem_rsp_valid     (imem_rsp_valid),
        .imem_rsp_data      (imem_rsp_data),
        .fetch_valid        (fetch_valid),
        .decode_ready       (decode_ready),
        .fetch_instruction  (fetch_instruction),
        .fetch_pc           (fetch_pc),
        .fetch_pc_plus_4    (fetch_pc_plus_4),
        .redirect_valid     (redirect_valid),
        .redirect_target    (redirect_target),
        .fetch_misaligned   (fetch_misaligned),
        .fetch_count        (fetch_count)
    );

    always #2.5 clk = ~clk;

    // Advance one rising edge and settle 1ns after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic accept_req();
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
    endtask

    task automatic respond(input logic [31:0] data);
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = data;
        tick();
        imem_rsp_valid = 1'b0;
    endtask

    task automatic consume();
        decode_ready = 1'b1;
        tick();
        decode_ready = 1'b0;
    endtask

    task automatic test_reset();
        tick();
        tick();
        n_checks++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL reset_req_valid got %0b want 0", imem_req_valid); end
        n_checks++; if (fetch_valid !== 1'b0) begin n_fail++; $display("FAIL reset_fetch_valid got %0b want 0", fetch_valid); end
        n_checks++; if (fetch_instruction !== NOP) begin n_fail++; $display("FAIL reset_instr got %h want %h", fetch_instruction, NOP); end
        n_checks++; if (fetch_pc_plus_4 !== 32'h4) begin n_fail++; $display("FAIL reset_pc4 got %h want 4", fetch_pc_plus_4); end
        n_checks++; if (fetch_count !== 32'h0) begin n_fail++; $display("FAIL reset_count got %h want 0", fetch_count); end
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_basic_fetch();
        n_checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin n_fail++; $display("FAIL basic_req got v=%0b a=%h want v=1 a=0", imem_req_valid, imem_req_addr); end
        accept_req();
        n_checks++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL basic_wait_req got %0b want 0", imem_req_valid); end
        respond(32'h0050_0093);
        n_checks++; if (fetch_valid !== 1'b1 || fetch_instruction !== 32'h0050_0093) begin n_fail++; $display("FAIL basic_deliver got v=%0b i=%h want v=1 i=00500093", fetch_valid, fetch_instruction); end
        n_checks++; if (fetch_pc !== 32'h0 || fetch_pc_plus_4 !== 32'h4) begin n_fail++; $display("FAIL basic_pc got pc=%h pc4=%h want 0/4", fetch_pc, fetch_pc_plus_4); end
        consume();
        n_checks++; if (fetch_count !== 32'd1 || fetch_valid !== 1'b0 || fetch_instruction !== NOP) begin n_fail++; $display("FAIL basic_consume got c=%0d v=%0b i=%h want c=1 v=0 i=nop", fetch_count, fetch_valid, fetch_instruction); end
        n_checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h4) begin n_fail++; $display("FAIL basic_next_req got v=%0b a=%h want v=1 a=4", imem_req_valid, imem_req_addr); end
    endtask

    task automatic test_decode_stall();
        accept_req();
        respond(32'h0010_0113);
        for (int i = 0; i < 5; i++) begin
            tick();
            n_checks++; if (fetch_valid !== 1'b1 || fetch_pc !== 32'h4 || fetch_instruction !== 32'h0010_0113 || imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL stall_hold[%0d] got v=%0b pc=%h i=%h rq=%0b want 1/4/00100113/0", i, fetch_valid, fetch_pc, fetch_instruction, imem_req_valid); end
        end
        consume();
        n_checks++; if (imem_req_addr !== 32'h8 || imem_req_valid !== 1'b1 || fetch_count !== 32'd2) begin n_fail++; $display("FAIL stall_release got a=%h v=%0b c=%0d want 8/1/2", imem_req_addr, imem_req_valid, fetch_count); end
    endtask

    task automatic test_redirect_discard();
        accept_req();
        redirect_valid  = 1'b1;
        redirect_target = 32'h0000_0100;
        tick();
        redirect_valid = 1'b0;
        n_checks++; if (imem_req_valid !== 1'b0 || fetch_misaligned !== 1'b0) begin n_fail++; $display("FAIL disc_wait got rq=%0b mis=%0b want 0/0", imem_req_valid, fetch_misaligned); end
        respond(32'hDEAD_BEEF);
        n_checks++; if (fetch_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h100) begin n_fail++; $display("FAIL disc_drop got v=%0b rq=%0b a=%h want 0/1/100", fetch_valid, imem_req_valid, imem_req_addr); end
        accept_req();
        respond(32'h0000_0293);
        n_checks++; if (fetch_valid !== 1'b1 || fetch_pc !== 32'h100 || fetch_instruction !== 32'h0000_0293) begin n_fail++; $display("FAIL disc_deliver got v=%0b pc=%h i=%h want 1/100/00000293", fetch_valid, fetch_pc, fetch_instruction); end
        consume();
        n_checks++; if (fetch_count !== 32'd3 || imem_req_addr !== 32'h104) begin n_fail++; $display("FAIL disc_after got c=%0d a=%h want 3/104", fetch_count, imem_req_addr); end
    endtask

    task automatic test_misaligned();
        redirect_valid  = 1'b1;
        redirect_target = 32'h0000_0102;
        #1;
        n_checks++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL mis_req_suppressed got %0b want 0", imem_req_valid); end
        tick();
        redirect_valid = 1'b0;
        #1;
        n_checks++; if (fetch_misaligned !== 1'b1 || imem_req_addr !== 32'h100 || imem_req_valid !== 1'b1) begin n_fail++; $display("FAIL mis_pulse got m=%0b a=%h v=%0b want 1/100/1", fetch_misaligned, imem_req_addr, imem_req_valid); end
        tick();
        n_checks++; if (fetch_misaligned !== 1'b0) begin n_fail++; $display("FAIL mis_one_cycle got %0b want 0", fetch_misaligned); end
    endtask

    task automatic test_req_backpressure();
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h100) begin n_fail++; $display("FAIL bp_stable[%0d] got v=%0b a=%h want 1/100", i, imem_req_valid, imem_req_addr); end
        end
        accept_req();
        for (int i = 0; i < 2; i++) begin
            n_checks++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL bp_single[%0d] got %0b want 0", i, imem_req_valid); end
            tick();
        end
        respond(32'h0030_0193);
        n_checks++; if (fetch_pc !== 32'h100 || fetch_instruction !== 32'h0030_0193) begin n_fail++; $display("FAIL bp_deliver got pc=%h i=%h want 100/00300193", fetch_pc, fetch_instruction); end
        consume();
        n_checks++; if (fetch_count !== 32'd4 || imem_req_addr !== 32'h104) begin n_fail++; $display("FAIL bp_after got c=%0d a=%h want 4/104", fetch_count, imem_req_addr); end
    endtask

    task automatic test_redirect_in_hold();
        accept_req();
        respond(32'h0040_0213);
        decode_ready    = 1'b1;
        redirect_valid  = 1'b1;
        redirect_target = 32'h0000_0200;
        tick();
        decode_ready   = 1'b0;
        redirect_valid = 1'b0;
        #1;
        n_checks++; if (fetch_valid !== 1'b0 || fetch_count !== 32'd5 || imem_req_addr !== 32'h200 || imem_req_valid !== 1'b1) begin n_fail++; $display("FAIL hold_redirect got v=%0b c=%0d a=%h rq=%0b want 0/5/200/1", fetch_valid, fetch_count, imem_req_addr, imem_req_valid); end
    endtask

    task automatic test_wrap_and_reset();
        redirect_valid  = 1'b1;
        redirect_target = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        #1;
        n_checks++; if (imem_req_addr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_req got %h want fffffffc", imem_req_addr); end
        accept_req();
        respond(32'h00A0_0513);
        n_checks++; if (fetch_pc !== 32'hFFFF_FFFC || fetch_pc_plus_4 !== 32'h0) begin n_fail++; $display("FAIL wrap_pc got pc=%h pc4=%h want fffffffc/0", fetch_pc, fetch_pc_plus_4); end
        consume();
        n_checks++; if (imem_req_addr !== 32'h0 || fetch_count !== 32'd6) begin n_fail++; $display("FAIL wrap_next got a=%h c=%0d want 0/6", imem_req_addr, fetch_count); end
        accept_req();
        rst_n = 1'b0;
        #1;
        n_checks++; if (imem_req_valid !== 1'b0 || fetch_valid !== 1'b0 || fetch_count !== 32'h0 || fetch_instruction !== NOP || fetch_pc !== 32'h0 || fetch_pc_plus_4 !== 32'h4 || fetch_misaligned !== 1'b0) begin n_fail++; $display("FAIL async_reset got rq=%0b v=%0b c=%0d i=%h pc=%h pc4=%h m=%0b want 0/0/0/nop/0/4/0", imem_req_valid, fetch_valid, fetch_count, fetch_instruction, fetch_pc, fetch_pc_plus_4, fetch_misaligned); end
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hBAD0_BAD0;
        tick();
        rst_n = 1'b1;
        tick();
        imem_rsp_valid = 1'b0;
        n_checks++; if (fetch_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin n_fail++; $display("FAIL late_rsp got v=%0b rq=%0b a=%h want 0/1/0", fetch_valid, imem_req_valid, imem_req_addr); end
    endtask

    initial begin
        test_reset();
        test_basic_fetch();
        test_decode_stall();
        test_redirect_discard();
        test_misaligned();
        test_req_backpressure();
        test_redirect_in_hold();
        test_wrap_and_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Fetch stage directly upstream of the decode/control/register-file datapath.
- Owns the program counter and issues one outstanding request at a time to the instruction memory over a valid/ready handshake.
- Buffers the returned word and presents instruction, PC and PC+4 to decode with a valid/ready handshake.
- Accepts redirects (branch/jump/jalr targets) from execute, discarding stale in-flight fetches.

Parameters:
- RESET_VECTOR, 32'h0000_0000, first PC fetched after reset.
- NOP_INSTRUCTION, 32'h0000_0013, value driven on fetch_instruction while no valid instruction is held.

Ports:
- pll_1_200MHz  input  1  sole clock, all state on rising edge.
- pll_1_locked_synced  input  1  reset; asynchronous, active-low.
- imem_req_valid  output  1  request to instruction memory.
- imem_req_ready  input  1  memory accepts request this cycle.
- imem_req_addr  output  32  word-aligned fetch address (= pc).
- imem_rsp_valid  input  1  response word valid (≥1 cycle after acceptance).
- imem_rsp_data  input  32  response instruction word.
- fetch_valid  output  1  fetch_instruction/fetch_pc valid for decode.
- decode_ready  input  1  decode consumes the held instruction.
- fetch_instruction  output  32  held instruction.
- fetch_pc  output  32  address of the held instruction.
- fetch_pc_plus_4  output  32  fetch_pc + 4, modulo 2^32.
- redirect_valid  input  1  execute requests PC change.
- redirect_target  input  32  new PC.
- fetch_misaligned  output  1  one-cycle pulse: redirect_target[1:0] != 0.
- fetch_count  output  32  instructions delivered to decode, wraps.

Behaviour:
- Reset (pll_1_locked_synced low, asynchronous): pc=RESET_VECTOR, state=S_REQ, discard=0, fetch_valid=0, fetch_instruction=NOP_INSTRUCTION, fetch_pc=RESET_VECTOR, fetch_pc_plus_4=RESET_VECTOR+4, fetch_misaligned=0, fetch_count=0; imem_req_valid=0 while in reset. Reset mid-transaction abandons it; any late imem_rsp_valid arriving in S_REQ is ignored.
- States: S_REQ (issue), S_WAIT (one request outstanding), S_HOLD (instruction presented).
- imem_req_valid = (state==S_REQ) && !redirect_valid (combinational); imem_req_addr = pc.
- S_REQ: if imem_req_valid && imem_req_ready -> S_WAIT. imem_req_valid stays high until accepted; imem_req_addr is stable while imem_req_valid is high.
- S_WAIT, imem_rsp_valid with discard=1: drop word, discard<=0 -> S_REQ.
- S_WAIT, imem_rsp_valid with discard=0: fetch_instruction<=imem_rsp_data, fetch_pc<=pc, fetch_pc_plus_4<=pc+4, pc<=pc+4, fetch_valid<=1 -> S_HOLD. Minimum latency from request acceptance to fetch_valid is 1 cycle after imem_rsp_valid.
- S_HOLD: outputs stable while fetch_valid && !decode_ready. On decode_ready: fetch_valid<=0, fetch_instruction<=NOP_INSTRUCTION, fetch_count<=fetch_count+1 -> S_REQ. No prefetch; peak throughput is 1 instruction per 3 cycles with 1-cycle memory.
- Redirect (highest priority, any state): pc<={redirect_target[31:2],2'b00}; fetch_misaligned pulses high the next cycle iff redirect_target[1:0]!=0.
  - In S_REQ: no request is issued that cycle; stay in S_REQ.
  - In S_WAIT without imem_rsp_valid: discard<=1, stay in S_WAIT.
  - In S_WAIT with imem_rsp_valid the same cycle: drop the word -> S_REQ.
  - In S_HOLD: fetch_valid<=0 -> S_REQ. If decode_ready is also high, the handshake completes (fetch_count increments) and the redirect still applies.
- Redirects while discard=1 update pc only; discard stays 1; exactly one response is dropped.
- PC arithmetic is modulo 2^32: pc=32'hFFFF_FFFC advances to 32'h0000_0000. fetch_count wraps at 2^32.

Test Plan:
- Reset release, 1-cycle memory returning 32'h00500093 at address 0 -> imem_req_addr=0; fetch_valid with fetch_pc=0, fetch_pc_plus_4=4; next request addr=4; fetch_count=1 after decode_ready.
- decode_ready held low 5 cycles in S_HOLD -> fetch_instruction/fetch_pc stable and no imem_req_valid; on release, next request at pc+4.
- Redirect to 32'h0000_0100 while a request to 8 is outstanding -> response for 8 dropped (fetch_valid stays 0); next request addr=32'h100; delivered fetch_pc=32'h100.
- Redirect to 32'h0000_0102 -> fetch_misaligned pulses for one cycle; request addr=32'h100.
- imem_req_ready held low 4 cycles -> imem_req_valid and imem_req_addr stable; exactly one request issued.
- Wrap: redirect to 32'hFFFF_FFFC, fetch -> fetch_pc_plus_4=0 and next request addr=0; reset asserted during S_WAIT -> all outputs at reset values immediately, late response ignored.
